// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path: opcodes, FSM state
// encodings and the select codes understood by the datapath blocks.
package ctrl_pkg;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    // Immediate generator format codes
    localparam logic [2:0] IMM_SEL_I    = 3'd0;
    localparam logic [2:0] IMM_SEL_S    = 3'd1;
    localparam logic [2:0] IMM_SEL_B    = 3'd2;
    localparam logic [2:0] IMM_SEL_J    = 3'd3;
    localparam logic [2:0] IMM_SEL_NONE = 3'd7;

    localparam logic [1:0] ALU_OP_ADD    = 2'd0;
    localparam logic [1:0] ALU_OP_BRANCH = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    // True for the opcodes this core executes; everything else traps
    function automatic logic isLegalOpcode(input logic [6:0] opc);
        return (opc == OPC_OPIMM) || (opc == OPC_OP) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JAL);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on the memory handshake and flags the cycle in
// which the wait budget runs out. Expiry is only raised while still waiting,
// so a ready arriving in the last allowed cycle is never overridden.
module mem_wait_timer #(
    parameter int TW          = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam logic [TW-1:0] LIMIT = TW'(MEM_TIMEOUT - 1);

    logic [TW-1:0] r_count;

    // Wait counter: cleared when a new access begins, saturates at the limit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_inc && (r_count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32I core. Steps each instruction through
// fetch/decode/execute/memory/writeback and decodes the datapath controls
// from the current state and opcode.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TW          = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] inst_i,
    input  logic        mem_ready_i,
    input  logic        br_taken_i,
    output logic        pc_we_o,
    output logic        ir_we_o,
    output logic        reg_we_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [2:0]  imm_sel_o,
    output logic        alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic [1:0]  wb_sel_o,
    output logic        pc_sel_o,
    output logic        trap_o,
    output logic [2:0]  state_o
);

    state_t     r_state;
    state_t     w_nextState;
    logic [6:0] w_opcode;
    logic       w_timerClr;
    logic       w_timerInc;
    logic       w_timeout;
    logic       w_unusedInstBits;

    assign w_opcode = inst_i[6:0];
    // The remaining instruction fields are consumed by the datapath, not here
    assign w_unusedInstBits = ^inst_i[31:7];

    // A fresh wait budget starts whenever we move into a requesting state
    assign w_timerClr = (w_nextState != r_state) &&
                        ((w_nextState == ST_FETCH) || (w_nextState == ST_MEM));
    assign w_timerInc = mem_req_o && !mem_ready_i;

    mem_wait_timer #(
        .TW          (TW),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_memWaitTimer (
        .i_clk     (clk_i),
        .i_rst_n   (rst_ni),
        .i_clr     (w_timerClr),
        .i_inc     (w_timerInc),
        .o_expired (w_timeout)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state selection; TRAP is absorbing until reset
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_FETCH: begin
                if (mem_ready_i)    w_nextState = ST_DECODE;
                else if (w_timeout) w_nextState = ST_TRAP;
            end
            ST_DECODE: begin
                w_nextState = isLegalOpcode(w_opcode) ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                case (w_opcode)
                    OPC_OPIMM, OPC_OP:   w_nextState = ST_WB;
                    OPC_LOAD, OPC_STORE: w_nextState = ST_MEM;
                    OPC_BRANCH, OPC_JAL: w_nextState = ST_FETCH;
                    default:             w_nextState = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                if (mem_ready_i)
                    w_nextState = (w_opcode == OPC_STORE) ? ST_FETCH : ST_WB;
                else if (w_timeout)
                    w_nextState = ST_TRAP;
            end
            ST_WB:   w_nextState = ST_FETCH;
            ST_TRAP: w_nextState = ST_TRAP;
            default: w_nextState = ST_TRAP;
        endcase
    end

    // Output decode; held inactive while reset is asserted so an access in
    // flight is abandoned immediately
    always_comb begin
        pc_we_o     = 1'b0;
        ir_we_o     = 1'b0;
        reg_we_o    = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        imm_sel_o   = IMM_SEL_NONE;
        alu_src_b_o = 1'b0;
        alu_op_o    = ALU_OP_ADD;
        wb_sel_o    = WB_SEL_ALU;
        pc_sel_o    = 1'b0;
        trap_o      = 1'b0;
        if (rst_ni) begin
            case (r_state)
                ST_FETCH: begin
                    mem_req_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_we_o = 1'b1;
                        pc_we_o = 1'b1;
                    end
                end
                ST_EXEC: begin
                    case (w_opcode)
                        OPC_OPIMM: begin
                            imm_sel_o   = IMM_SEL_I;
                            alu_src_b_o = 1'b1;
                            alu_op_o    = ALU_OP_FUNCT;
                        end
                        OPC_OP: begin
                            alu_op_o = ALU_OP_FUNCT;
                        end
                        OPC_LOAD: begin
                            imm_sel_o   = IMM_SEL_I;
                            alu_src_b_o = 1'b1;
                        end
                        OPC_STORE: begin
                            imm_sel_o   = IMM_SEL_S;
                            alu_src_b_o = 1'b1;
                        end
                        OPC_BRANCH: begin
                            imm_sel_o = IMM_SEL_B;
                            alu_op_o  = ALU_OP_BRANCH;
                            pc_we_o   = br_taken_i;
                            pc_sel_o  = br_taken_i;
                        end
                        OPC_JAL: begin
                            imm_sel_o = IMM_SEL_J;
                            reg_we_o  = 1'b1;
                            wb_sel_o  = WB_SEL_PC4;
                            pc_we_o   = 1'b1;
                            pc_sel_o  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = (w_opcode == OPC_STORE);
                    imm_sel_o = (w_opcode == OPC_STORE) ? IMM_SEL_S : IMM_SEL_I;
                end
                ST_WB: begin
                    reg_we_o = 1'b1;
                    wb_sel_o = (w_opcode == OPC_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
                end
                ST_TRAP: begin
                    trap_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, hand-written
// multi-cycle corner cases, and randomized instruction streams compared with
// an instruction-level reference model.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       pcWe;
        logic       irWe;
        logic       regWe;
        logic       memReq;
        logic       memWe;
        logic [2:0] immSel;
        logic       aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] wbSel;
        logic       pcSel;
        logic       trap;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic        rdy;
        logic        br;
        exp_t        want;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] inst_i = 32'h0;
    logic        mem_ready_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic        pc_we_o, ir_we_o, reg_we_o, mem_req_o, mem_we_o;
    logic [2:0]  imm_sel_o;
    logic        alu_src_b_o;
    logic [1:0]  alu_op_o;
    logic [1:0]  wb_sel_o;
    logic        pc_sel_o, trap_o;
    logic [2:0]  state_o;

    int nChecks = 0;
    int nErrors = 0;
    int cycleNo = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(15), .TW(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inst_i      (inst_i),
        .mem_ready_i (mem_ready_i),
        .br_taken_i  (br_taken_i),
        .pc_we_o     (pc_we_o),
        .ir_we_o     (ir_we_o),
        .reg_we_o    (reg_we_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .imm_sel_o   (imm_sel_o),
        .alu_src_b_o (alu_src_b_o),
        .alu_op_o    (alu_op_o),
        .wb_sel_o    (wb_sel_o),
        .pc_sel_o    (pc_sel_o),
        .trap_o      (trap_o),
        .state_o     (state_o)
    );

    // Free-running clock, 10 time units per period
    always #5 clk_i = ~clk_i;

    function automatic exp_t mk(input int st, input bit pcWe, input bit irWe, input bit regWe,
                                input bit memReq, input bit memWe, input int imm, input bit srcB,
                                input int aop, input int wb, input bit pcSel, input bit trap);
        exp_t e;
        e.st = 3'(st); e.pcWe = pcWe; e.irWe = irWe; e.regWe = regWe;
        e.memReq = memReq; e.memWe = memWe; e.immSel = 3'(imm); e.aluSrcB = srcB;
        e.aluOp = 2'(aop); e.wbSel = 2'(wb); e.pcSel = pcSel; e.trap = trap;
        return e;
    endfunction

    // Reference model: what each phase of an instruction must present,
    // written from the per-opcode behaviour rules
    function automatic exp_t modelOut(input int phase, input logic [6:0] opc,
                                      input logic rdy, input logic br);
        exp_t e;
        e = mk(phase, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
        case (phase)
            0: begin e.memReq = 1; e.irWe = rdy; e.pcWe = rdy; end
            2: begin
                case (opc)
                    7'b0010011: begin e.immSel = 0; e.aluSrcB = 1; e.aluOp = 2; end
                    7'b0110011: begin e.aluOp = 2; end
                    7'b0000011: begin e.immSel = 0; e.aluSrcB = 1; end
                    7'b0100011: begin e.immSel = 1; e.aluSrcB = 1; end
                    7'b1100011: begin e.immSel = 2; e.aluOp = 1; e.pcWe = br; e.pcSel = br; end
                    7'b1101111: begin e.immSel = 3; e.regWe = 1; e.wbSel = 2; e.pcWe = 1; e.pcSel = 1; end
                    default: ;
                endcase
            end
            3: begin
                e.memReq = 1;
                e.memWe  = (opc == 7'b0100011);
                e.immSel = (opc == 7'b0100011) ? 3'd1 : 3'd0;
            end
            4: begin e.regWe = 1; e.wbSel = (opc == 7'b0000011) ? 2'd1 : 2'd0; end
            7: e.trap = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic applyStimulus(input logic rdy, input logic br);
        mem_ready_i = rdy;
        br_taken_i  = br;
    endtask

    task automatic checkOutput(input exp_t want, input string tag);
        exp_t got;
        got = '{state_o, pc_we_o, ir_we_o, reg_we_o, mem_req_o, mem_we_o, imm_sel_o,
                alu_src_b_o, alu_op_o, wb_sel_o, pc_sel_o, trap_o};
        nChecks++;
        if (got !== want) begin
            nErrors++;
            $display("[TB] FAIL %s cycle %0d: got %h want %h (st,pcwe,irwe,regwe,req,we,imm,srcb,aluop,wb,pcsel,trap)",
                     tag, cycleNo, got, want);
        end
    endtask

    // One clock: drive inputs, check at the falling edge, advance past the rising edge
    task automatic step(input logic rdy, input logic br, input exp_t want, input string tag);
        applyStimulus(rdy, br);
        @(negedge clk_i);
        checkOutput(want, tag);
        @(posedge clk_i);
        #1;
        cycleNo++;
    endtask

    task automatic doReset();
        rst_ni = 1'b0;
        applyStimulus(1'b0, 1'b0);
        @(negedge clk_i);
        checkOutput(mk(0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0), "reset_hold");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    vec_t vecs[22];
    exp_t offE, fetchDone, fetchWait, decodeE, trapE, lwExec, lwMem, lwWb;
    logic [6:0] opcTable[6];

    initial begin
        offE      = mk(0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
        fetchDone = mk(0, 1, 1, 0, 1, 0, 7, 0, 0, 0, 0, 0);
        fetchWait = mk(0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0, 0);
        decodeE   = mk(1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
        trapE     = mk(7, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 1);
        lwExec    = mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        lwMem     = mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        lwWb      = mk(4, 0, 0, 1, 0, 0, 7, 0, 0, 1, 0, 0);
        opcTable  = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};

        // addi x1,x0,5
        vecs[0]  = '{32'h00500093, 1'b1, 1'b0, fetchDone};
        vecs[1]  = '{32'h00500093, 1'b0, 1'b0, decodeE};
        vecs[2]  = '{32'h00500093, 1'b0, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0)};
        vecs[3]  = '{32'h00500093, 1'b1, 1'b0, mk(4, 0, 0, 1, 0, 0, 7, 0, 0, 0, 0, 0)};
        // beq taken
        vecs[4]  = '{32'h00208463, 1'b1, 1'b0, fetchDone};
        vecs[5]  = '{32'h00208463, 1'b0, 1'b1, decodeE};
        vecs[6]  = '{32'h00208463, 1'b0, 1'b1, mk(2, 1, 0, 0, 0, 0, 2, 0, 1, 0, 1, 0)};
        // beq not taken
        vecs[7]  = '{32'h00208463, 1'b1, 1'b0, fetchDone};
        vecs[8]  = '{32'h00208463, 1'b0, 1'b0, decodeE};
        vecs[9]  = '{32'h00208463, 1'b0, 1'b0, mk(2, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0)};
        // sw
        vecs[10] = '{32'h0020A023, 1'b1, 1'b0, fetchDone};
        vecs[11] = '{32'h0020A023, 1'b0, 1'b0, decodeE};
        vecs[12] = '{32'h0020A023, 1'b0, 1'b0, mk(2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0)};
        vecs[13] = '{32'h0020A023, 1'b1, 1'b0, mk(3, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0)};
        // jal x1,8
        vecs[14] = '{32'h008000EF, 1'b1, 1'b0, fetchDone};
        vecs[15] = '{32'h008000EF, 1'b0, 1'b0, decodeE};
        vecs[16] = '{32'h008000EF, 1'b0, 1'b0, mk(2, 1, 0, 1, 0, 0, 3, 0, 0, 2, 1, 0)};
        // add x3,x1,x2
        vecs[17] = '{32'h002081B3, 1'b1, 1'b0, fetchDone};
        vecs[18] = '{32'h002081B3, 1'b0, 1'b0, decodeE};
        vecs[19] = '{32'h002081B3, 1'b0, 1'b0, mk(2, 0, 0, 0, 0, 0, 7, 0, 2, 0, 0, 0)};
        vecs[20] = '{32'h002081B3, 1'b0, 1'b0, mk(4, 0, 0, 1, 0, 0, 7, 0, 0, 0, 0, 0)};
        vecs[21] = '{32'h00000000, 1'b0, 1'b0, fetchWait};

        doReset();

        for (int i = 0; i < 22; i++) begin
            inst_i = vecs[i].inst;
            step(vecs[i].rdy, vecs[i].br, vecs[i].want, $sformatf("vec%0d", i));
        end

        // lw with memory stalled for three cycles
        doReset();
        inst_i = 32'h0000A103;
        step(1, 0, fetchDone, "lw_fetch");
        step(0, 0, decodeE, "lw_decode");
        step(0, 0, lwExec, "lw_exec");
        for (int k = 0; k < 3; k++) step(0, 0, lwMem, "lw_mem_wait");
        step(1, 0, lwMem, "lw_mem_done");
        step(0, 0, lwWb, "lw_wb");
        step(0, 0, fetchWait, "lw_back_fetch");

        // Illegal opcode traps and stays trapped
        doReset();
        inst_i = 32'h0000007F;
        step(1, 0, fetchDone, "ill_fetch");
        step(0, 0, decodeE, "ill_decode");
        for (int k = 0; k < 4; k++) step(k[0], 1, trapE, "ill_trap_held");

        // Fetch stalled forever: fifteen waits then trap
        doReset();
        inst_i = 32'h00500093;
        for (int k = 0; k < 15; k++) step(0, 0, fetchWait, "to_fetch_wait");
        step(1, 0, trapE, "to_trap");
        step(1, 0, trapE, "to_trap_held");

        // Ready in the last allowed cycle wins; MEM gets a fresh budget
        doReset();
        inst_i = 32'h0000A103;
        for (int k = 0; k < 14; k++) step(0, 0, fetchWait, "edge_fetch_wait");
        step(1, 0, fetchDone, "edge_fetch_ready");
        step(0, 0, decodeE, "edge_decode");
        step(0, 0, lwExec, "edge_exec");
        for (int k = 0; k < 14; k++) step(0, 0, lwMem, "edge_mem_wait");
        step(1, 0, lwMem, "edge_mem_ready");
        step(0, 0, lwWb, "edge_wb");

        // Reset asserted in the middle of a memory access
        doReset();
        inst_i = 32'h0000A103;
        step(1, 0, fetchDone, "rm_fetch");
        step(0, 0, decodeE, "rm_decode");
        step(0, 0, lwExec, "rm_exec");
        step(0, 0, lwMem, "rm_mem");
        rst_ni = 1'b0;
        #1;
        checkOutput(offE, "rm_req_drop");
        @(negedge clk_i);
        checkOutput(offE, "rm_in_reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step(0, 0, fetchWait, "rm_after_release");

        // Randomized instruction streams against the reference model
        doReset();
        for (int n = 0; n < 80; n++) begin
            int          cls;
            int          waits;
            logic [6:0]  opc;
            logic [31:0] rnd;
            logic        br;
            cls = int'($urandom_range(0, 5));
            opc = opcTable[cls];
            rnd = $urandom();
            inst_i = {rnd[31:7], opc};
            waits = int'($urandom_range(0, 4));
            for (int k = 0; k < waits; k++) begin
                br = 1'($urandom_range(0, 1));
                step(0, br, modelOut(0, opc, 0, br), "rnd_fetch_wait");
            end
            step(1, 0, modelOut(0, opc, 1, 0), "rnd_fetch");
            step(1'($urandom_range(0, 1)), 0, modelOut(1, opc, 0, 0), "rnd_decode");
            br = 1'($urandom_range(0, 1));
            step(0, br, modelOut(2, opc, 0, br), "rnd_exec");
            if (opc == 7'b0000011 || opc == 7'b0100011) begin
                waits = int'($urandom_range(0, 4));
                for (int k = 0; k < waits; k++) step(0, 0, modelOut(3, opc, 0, 0), "rnd_mem_wait");
                step(1, 0, modelOut(3, opc, 1, 0), "rnd_mem");
            end
            if (opc == 7'b0010011 || opc == 7'b0110011 || opc == 7'b0000011) begin
                step(1'($urandom_range(0, 1)), 0, modelOut(4, opc, 0, 0), "rnd_wb");
            end
        end

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
